// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with IDLE / RUN / DONE control. While running, each
//   tick strobe decrements the count. In one-shot mode the final decrement
//   ends in DONE. In periodic mode the final decrement reloads the count and
//   the counter keeps running. Every terminal decrement emits a one-cycle
//   tc pulse.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   load      capture load_val into the reload register and count; go IDLE
//   load_val  reload / start value (WIDTH bits)
//   start     begin a countdown from the reload value (IDLE or DONE only)
//   stop      abort a running countdown; count holds its value
//   tick      decrement strobe, effective only in RUN
//   mode      0 = one-shot, 1 = periodic; latched when start is accepted
//   count     current counter value (registered)
//   busy      high while in RUN (registered)
//   done      high while in DONE (registered)
//   tc        terminal-count pulse, one cycle (registered)
module countdown_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             mode_q;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Input priority: reset > load > stop > start > tick.
    // busy/done are written alongside every state change, so they always
    // mirror the registered state without any extra decode delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            mode_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tc         <= 1'b0;
        end else begin
            // tc is high only in the cycle after a terminal decrement.
            tc <= 1'b0;

            if (load) begin
                reload_reg <= load_val;
                count      <= load_val;
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else if (stop && (state == RUN)) begin
                // Stop also wins over a coincident final tick: no tc.
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start && (state != RUN) && (reload_reg != '0)) begin
                count  <= reload_reg;
                mode_q <= mode;
                state  <= RUN;
                busy   <= 1'b1;
                done   <= 1'b0;
            end else if ((state == RUN) && tick) begin
                if (count == ONE) begin
                    tc <= 1'b1;
                    if (mode_q) begin
                        count <= reload_reg;
                    end else begin
                        count <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else if (count != '0) begin
                    count <= count - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed bench for countdown_timer (WIDTH=8). Inputs change 1 ns after
//   each rising edge; outputs are sampled at that same point, after the
//   edge has settled.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic       tick;
    logic       mode;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       tc;

    int unsigned total;
    int unsigned bad;

    countdown_timer #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .mode     (mode),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic want(input string tag, input logic [7:0] c, input logic b,
                        input logic d, input logic t);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".tc"},    32'(tc),    32'(t));
    endtask

    // Apply one cycle of inputs, then advance past the next rising edge.
    task automatic step(input logic rs, input logic ld, input logic [7:0] lv,
                        input logic st, input logic sp, input logic tk,
                        input logic md);
        reset    = rs;
        load     = ld;
        load_val = lv;
        start    = st;
        stop     = sp;
        tick     = tk;
        mode     = md;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pexp [12];
        logic [7:0] sexp [6];
        logic       stc  [6];
        logic       stk  [6];
        int unsigned tc_seen;

        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        start    = 1'b0;
        stop     = 1'b0;
        tick     = 1'b0;
        mode     = 1'b0;
        #2;

        // Reset state
        step(1, 0, 8'd0, 0, 0, 0, 0);
        want("reset", 8'd0, 0, 0, 0);

        // Zero and priority
        step(0, 0, 8'd0, 1, 0, 0, 0);
        want("start_after_reset", 8'd0, 0, 0, 0);
        step(0, 1, 8'd0, 0, 0, 0, 0);
        want("load0", 8'd0, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 1, 0);
        want("start_reload0", 8'd0, 0, 0, 0);
        step(0, 1, 8'd7, 1, 0, 1, 0);
        want("load_and_start", 8'd7, 0, 0, 0);

        // One-shot: load 3, start mode=0, tick every cycle
        step(0, 1, 8'd3, 0, 0, 0, 0);
        want("os_load", 8'd3, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 1, 0);
        want("os_start", 8'd3, 1, 0, 0);
        // start while running must not restart the countdown
        step(0, 0, 8'd0, 1, 0, 1, 0);
        want("os_t1_start_in_run", 8'd2, 1, 0, 0);
        step(0, 0, 8'd0, 0, 0, 1, 0);
        want("os_t2", 8'd1, 1, 0, 0);
        step(0, 0, 8'd0, 0, 0, 1, 0);
        want("os_t3_terminal", 8'd0, 0, 1, 1);
        step(0, 0, 8'd0, 0, 0, 1, 0);
        want("os_done_hold", 8'd0, 0, 1, 0);
        step(0, 0, 8'd0, 0, 1, 1, 0);
        want("os_stop_in_done", 8'd0, 0, 1, 0);

        // Periodic: load 4, start mode=1, 12 ticks; mode flipped mid-run
        pexp = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
        step(0, 1, 8'd4, 0, 0, 0, 1);
        want("per_load", 8'd4, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 1, 1);
        want("per_start", 8'd4, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 8'd0, 0, 0, 1, (i >= 5) ? 1'b0 : 1'b1);
            want($sformatf("per_tick%0d", i), pexp[i], 1, 0, (i % 4) == 3);
        end
        // tc is high now; a load here leaves that pulse alone and then clears it
        step(0, 1, 8'd9, 0, 0, 1, 0);
        want("load_after_tc", 8'd9, 0, 0, 0);

        // Sparse tick: load 2, start, tick on every third cycle
        sexp = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
        stk  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        stc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        step(0, 1, 8'd2, 0, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 0, 0);
        want("sp_start", 8'd2, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 8'd0, 0, 0, stk[i], 0);
            want($sformatf("sp_cyc%0d", i + 1), sexp[i], i != 5, i == 5, stc[i]);
        end

        // Stop at terminal: stop with the final tick wins
        step(0, 1, 8'd5, 0, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 0, 0);
        want("st_start", 8'd5, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'd0, 0, 0, 1, 0);
        want("st_before_final", 8'd1, 1, 0, 0);
        step(0, 0, 8'd0, 0, 1, 1, 0);
        want("st_stop_final", 8'd1, 0, 0, 0);
        step(0, 0, 8'd0, 0, 0, 1, 0);
        want("st_idle_no_decr", 8'd1, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 0, 0);
        want("st_restart", 8'd5, 1, 0, 0);

        // Full-width period: reload 255, periodic
        step(0, 1, 8'd255, 0, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 0, 1);
        want("max_start", 8'd255, 1, 0, 0);
        tc_seen = 0;
        for (int i = 0; i < 254; i++) begin
            step(0, 0, 8'd0, 0, 0, 1, 0);
            if (tc === 1'b1) tc_seen++;
        end
        chk("max_no_early_tc", 32'(tc_seen), 32'd0);
        want("max_t254", 8'd1, 1, 0, 0);
        step(0, 0, 8'd0, 0, 0, 1, 0);
        want("max_t255", 8'd255, 1, 0, 1);

        // Reset mid-run
        step(0, 1, 8'd200, 0, 0, 0, 0);
        step(0, 0, 8'd0, 1, 0, 0, 0);
        for (int i = 0; i < 50; i++) step(0, 0, 8'd0, 0, 0, 1, 0);
        want("rr_after50", 8'd150, 1, 0, 0);
        step(1, 0, 8'd0, 0, 0, 1, 0);
        want("rr_reset", 8'd0, 0, 0, 0);
        // reload register was cleared, so start is ignored
        step(0, 0, 8'd0, 1, 0, 1, 0);
        want("rr_start_ignored", 8'd0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
